// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// Hazard and forwarding controller for a five-stage (IF/ID/EX/MEM/WB) pipeline.
// Keeps a shadow copy of the EX/MEM/WB destination info and derives stalls,
// flushes and operand-forwarding selects from it.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   id_valid               ID stage holds a real instruction
//   id_rs1_addr/_used      ID source 1 address / source actually read
//   id_rs2_addr/_used      ID source 2 address / source actually read
//   id_rd_addr             ID destination register
//   id_rf_wen, id_is_load  ID writes the register file / value comes from memory
//   ex_jump_flag           EX instruction redirects the PC
//   stall                  hold PC and IF/ID (combinational)
//   flush_if_id            bubble IF/ID (combinational)
//   flush_id_ex            bubble ID/EX (combinational)
//   fwd_a_sel, fwd_b_sel   EX operand source: 0 ID/EX, 1 EX/MEM, 2 MEM/WB (registered)
//   id_wb_fwd_a/_b         ID must bypass the register file from the WB value (combinational)
//   stall_cnt, flush_cnt   saturating event counters (registered)
module pipe_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_rf_wen,
  input  logic                  id_is_load,
  input  logic                  ex_jump_flag,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  id_wb_fwd_a,
  output logic                  id_wb_fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rf_wen;
    logic                  is_load;
  } shadow_t;

  shadow_t ex_q, mem_q, wb_q;
  shadow_t id_entry;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic hazard, jump, issue;
  logic [1:0] sel_a_d, sel_b_d;

  // A shadow entry produces the value a source reads; x0 never produces.
  function automatic logic hit(input shadow_t e, input logic [REG_ADDR_W-1:0] addr,
                               input logic used);
    return e.valid && e.rf_wen && (e.rd != '0) && (e.rd == addr) && used;
  endfunction

  // Hazard detection, jump priority and forwarding-select decode.
  always_comb begin
    ex_hit_a    = hit(ex_q,  id_rs1_addr, id_rs1_used);
    ex_hit_b    = hit(ex_q,  id_rs2_addr, id_rs2_used);
    mem_hit_a   = hit(mem_q, id_rs1_addr, id_rs1_used);
    mem_hit_b   = hit(mem_q, id_rs2_addr, id_rs2_used);
    id_wb_fwd_a = hit(wb_q,  id_rs1_addr, id_rs1_used);
    id_wb_fwd_b = hit(wb_q,  id_rs2_addr, id_rs2_used);

    // Without forwarding every in-flight producer ahead of WB must drain.
    if (FWD_EN) hazard = id_valid && (ex_hit_a || ex_hit_b) && ex_q.is_load;
    else        hazard = id_valid && (ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b);

    // A jump squashes the stalled instruction anyway, so it overrides the stall.
    jump        = ex_jump_flag && ex_q.valid;
    stall       = hazard && !jump;
    flush_if_id = jump;
    flush_id_ex = hazard || jump;
    issue       = id_valid && !flush_id_ex;

    id_entry = '{valid: 1'b1, rd: id_rd_addr, rf_wen: id_rf_wen, is_load: id_is_load};

    // Youngest producer wins; a load in EX is never forwarded from EX/MEM.
    sel_a_d = 2'd0;
    sel_b_d = 2'd0;
    if (FWD_EN && issue) begin
      if (ex_hit_a && !ex_q.is_load) sel_a_d = 2'd1;
      else if (mem_hit_a)            sel_a_d = 2'd2;
      if (ex_hit_b && !ex_q.is_load) sel_b_d = 2'd1;
      else if (mem_hit_b)            sel_b_d = 2'd2;
    end
  end

  // Shadow pipeline, registered selects and saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= 2'd0;
      fwd_b_sel <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_q      <= mem_q;
      mem_q     <= ex_q;
      ex_q      <= issue ? id_entry : '0;
      fwd_a_sel <= sel_a_d;
      fwd_b_sel <= sel_b_d;
      if (stall && (stall_cnt != CNT_MAX))       stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if_id && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit. Two instances share the stimulus:
// index 0 = no forwarding with 2-bit counters, index 1 = forwarding with 16-bit counters.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       id_rs1_used, id_rs2_used, id_rf_wen, id_is_load, ex_jump_flag;

  logic       stall0, fif0, fie0, wba0, wbb0;
  logic [1:0] sa0, sb0;
  logic [1:0] sc0, fc0;
  logic       stall1, fif1, fie1, wba1, wbb1;
  logic [1:0] sa1, sb1;
  logic [15:0] sc1, fc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(2)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .ex_jump_flag(ex_jump_flag), .stall(stall0), .flush_if_id(fif0), .flush_id_ex(fie0),
    .fwd_a_sel(sa0), .fwd_b_sel(sb0), .id_wb_fwd_a(wba0), .id_wb_fwd_b(wbb0),
    .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .ex_jump_flag(ex_jump_flag), .stall(stall1), .flush_if_id(fif1), .flush_id_ex(fie1),
    .fwd_a_sel(sa1), .fwd_b_sel(sb1), .id_wb_fwd_a(wba1), .id_wb_fwd_b(wbb1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  logic        o_stall [2], o_fif [2], o_fie [2], o_wba [2], o_wbb [2];
  logic [1:0]  o_sa [2], o_sb [2];
  logic [15:0] o_sc [2], o_fc [2];

  always_comb begin
    o_stall[0] = stall0; o_fif[0] = fif0; o_fie[0] = fie0; o_wba[0] = wba0; o_wbb[0] = wbb0;
    o_sa[0] = sa0; o_sb[0] = sb0; o_sc[0] = 16'(sc0); o_fc[0] = 16'(fc0);
    o_stall[1] = stall1; o_fif[1] = fif1; o_fie[1] = fie1; o_wba[1] = wba1; o_wbb[1] = wbb1;
    o_sa[1] = sa1; o_sb[1] = sb1; o_sc[1] = sc1; o_fc[1] = fc1;
  end

  // ---------------- reference model ----------------
  // pipe[m][age]: age 0 = instruction in EX, 1 = MEM, 2 = WB.
  typedef struct { bit v; int rd; bit w; bit ld; } ent_t;
  ent_t   pipe [2][3];
  int     m_sa [2], m_sb [2];
  longint m_scnt [2], m_fcnt [2];
  bit     e_stall [2], e_fif [2], e_fie [2], e_wba [2], e_wbb [2];

  function automatic bit hit(ent_t e, int a, bit u);
    return e.v && e.w && (e.rd != 0) && (e.rd == a) && u;
  endfunction

  function automatic longint sat(longint c, int m);
    longint mx;
    mx = (m == 0) ? 64'd3 : 64'd65535;
    return (c > mx) ? mx : c;
  endfunction

  function automatic int pick_sel(int m, int a, bit u);
    if (m == 0) return 0;
    if (hit(pipe[m][0], a, u) && !pipe[m][0].ld) return 1;
    if (hit(pipe[m][1], a, u)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) pipe[m][k] = '{0, 0, 0, 0};
      m_sa[m] = 0; m_sb[m] = 0; m_scnt[m] = 0; m_fcnt[m] = 0;
    end
  endtask

  task automatic eval_model();
    int a1, a2;
    bit u1, u2, need, j;
    a1 = int'(id_rs1_addr); a2 = int'(id_rs2_addr);
    u1 = id_rs1_used; u2 = id_rs2_used;
    for (int m = 0; m < 2; m++) begin
      if (m == 1)
        need = id_valid && (hit(pipe[m][0], a1, u1) || hit(pipe[m][0], a2, u2)) && pipe[m][0].ld;
      else
        need = id_valid && (hit(pipe[m][0], a1, u1) || hit(pipe[m][0], a2, u2) ||
                            hit(pipe[m][1], a1, u1) || hit(pipe[m][1], a2, u2));
      j = ex_jump_flag && pipe[m][0].v;
      e_stall[m] = need && !j;
      e_fif[m]   = j;
      e_fie[m]   = need || j;
      e_wba[m]   = hit(pipe[m][2], a1, u1);
      e_wbb[m]   = hit(pipe[m][2], a2, u2);
    end
  endtask

  task automatic advance_model();
    bit enter;
    for (int m = 0; m < 2; m++) begin
      enter = id_valid && !e_fie[m];
      m_sa[m] = enter ? pick_sel(m, int'(id_rs1_addr), id_rs1_used) : 0;
      m_sb[m] = enter ? pick_sel(m, int'(id_rs2_addr), id_rs2_used) : 0;
      if (e_stall[m]) m_scnt[m]++;
      if (e_fif[m])   m_fcnt[m]++;
      pipe[m][2] = pipe[m][1];
      pipe[m][1] = pipe[m][0];
      if (enter) pipe[m][0] = '{1, int'(id_rd_addr), id_rf_wen, id_is_load};
      else       pipe[m][0] = '{0, 0, 0, 0};
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                       input int d, input bit w, input bit l, input bit j);
    id_valid = v; id_rs1_addr = 5'(a1); id_rs1_used = u1;
    id_rs2_addr = 5'(a2); id_rs2_used = u2; id_rd_addr = 5'(d);
    id_rf_wen = w; id_is_load = l; ex_jump_flag = j;
    #1;
    eval_model();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    eval_model();
    @(posedge clk);
    if (!reset) advance_model();
    #1;
    eval_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    // Reader of x1 plus an unqualified jump flag: nothing in flight, so all quiet.
    drive(1, 1, 1, 1, 1, 2, 1, 1, 1);
    for (int m = 0; m < 2; m++) begin
      checks++; if (o_stall[m] !== 1'b0) begin failures++; $display("FAIL rst_stall dut%0d got=%0b exp=0", m, o_stall[m]); end
      checks++; if (o_fif[m] !== 1'b0 || o_fie[m] !== 1'b0) begin failures++; $display("FAIL rst_flush dut%0d got=%0b%0b exp=00", m, o_fif[m], o_fie[m]); end
      checks++; if (o_wba[m] !== 1'b0 || o_wbb[m] !== 1'b0) begin failures++; $display("FAIL rst_wbfwd dut%0d got=%0b%0b exp=00", m, o_wba[m], o_wbb[m]); end
      checks++; if (o_sa[m] !== 2'd0 || o_sb[m] !== 2'd0) begin failures++; $display("FAIL rst_sel dut%0d got=%0d/%0d exp=0/0", m, o_sa[m], o_sb[m]); end
      checks++; if (o_sc[m] !== 16'd0 || o_fc[m] !== 16'd0) begin failures++; $display("FAIL rst_cnt dut%0d got=%0d/%0d exp=0/0", m, o_sc[m], o_fc[m]); end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 1, 1, 1, 1, 2, 1, 1, 1);
    checks++; if (o_fif[1] !== 1'b0) begin failures++; $display("FAIL unqual_jump got=%0b exp=0", o_fif[1]); end
  endtask

  task automatic test_fwd_alu();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);   // add x1
    tick();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);   // add x2 = x1 + x1
    checks++; if (o_stall[1] !== 1'b0) begin failures++; $display("FAIL alu_nostall got=%0b exp=0", o_stall[1]); end
    tick();
    idle();
    checks++; if (o_sa[1] !== 2'd1 || o_sb[1] !== 2'd1) begin failures++; $display("FAIL alu_sel got=%0d/%0d exp=1/1", o_sa[1], o_sb[1]); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);   // lw x5
    tick();
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0);   // add x6 = x5 + x0
    checks++; if (o_stall[1] !== 1'b1 || o_fie[1] !== 1'b1 || o_fif[1] !== 1'b0) begin failures++; $display("FAIL lu_stall got=%0b%0b%0b exp=110", o_stall[1], o_fie[1], o_fif[1]); end
    tick();
    checks++; if (o_stall[1] !== 1'b0) begin failures++; $display("FAIL lu_release got=%0b exp=0", o_stall[1]); end
    tick();
    idle();
    checks++; if (o_sa[1] !== 2'd2 || o_sb[1] !== 2'd0) begin failures++; $display("FAIL lu_sel got=%0d/%0d exp=2/0", o_sa[1], o_sb[1]); end
    checks++; if (o_sc[1] !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", o_sc[1]); end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);   // load into x0
    tick();
    drive(1, 0, 1, 0, 1, 7, 1, 0, 0);   // reads x0 twice
    for (int m = 0; m < 2; m++) begin
      checks++; if (o_stall[m] !== 1'b0 || o_wba[m] !== 1'b0) begin failures++; $display("FAIL x0_hazard dut%0d got=%0b%0b exp=00", m, o_stall[m], o_wba[m]); end
    end
    tick();
    idle();
    checks++; if (o_sa[1] !== 2'd0 || o_sb[1] !== 2'd0) begin failures++; $display("FAIL x0_sel got=%0d/%0d exp=0/0", o_sa[1], o_sb[1]); end
    tick();
  endtask

  task automatic test_jump_vs_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);   // lw x5
    tick();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 1);   // load-use consumer, jump in EX
    checks++; if (o_stall[1] !== 1'b0 || o_fif[1] !== 1'b1 || o_fie[1] !== 1'b1) begin failures++; $display("FAIL jmp_prio got=%0b%0b%0b exp=011", o_stall[1], o_fif[1], o_fie[1]); end
    tick();
    idle();
    checks++; if (o_fc[1] !== 16'd1 || o_sc[1] !== 16'd0) begin failures++; $display("FAIL jmp_cnt got=%0d/%0d exp=1/0", o_fc[1], o_sc[1]); end
    checks++; if (o_fif[1] !== 1'b0) begin failures++; $display("FAIL jmp_oneshot got=%0b exp=0", o_fif[1]); end
    tick();
    // The squashed writer of x6 would now sit in MEM; the no-forwarding unit would stall on it.
    drive(1, 6, 1, 0, 0, 7, 1, 0, 0);
    checks++; if (o_stall[0] !== 1'b0) begin failures++; $display("FAIL jmp_squash got=%0b exp=0", o_stall[0]); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_nofwd();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);   // add x3
    tick();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0);   // add x4 = x3
    checks++; if (o_stall[0] !== 1'b1) begin failures++; $display("FAIL nf_stall1 got=%0b exp=1", o_stall[0]); end
    tick();
    checks++; if (o_stall[0] !== 1'b1) begin failures++; $display("FAIL nf_stall2 got=%0b exp=1", o_stall[0]); end
    tick();
    checks++; if (o_stall[0] !== 1'b0 || o_wba[0] !== 1'b1) begin failures++; $display("FAIL nf_wbfwd got=%0b%0b exp=01", o_stall[0], o_wba[0]); end
    tick();
    idle();
    checks++; if (o_sa[0] !== 2'd0) begin failures++; $display("FAIL nf_sel got=%0d exp=0", o_sa[0]); end
    checks++; if (o_sc[0] !== 16'd2) begin failures++; $display("FAIL nf_cnt got=%0d exp=2", o_sc[0]); end
    tick();
  endtask

  task automatic test_saturate_and_reset();
    int k;
    bit held;
    do_reset();
    k = 0;
    for (int c = 0; c < 40 && m_scnt[0] < 5; c++) begin
      drive(1, (k == 0) ? 0 : 9 + k, 1, 0, 0, 10 + k, 1, 0, 0);
      held = e_stall[0];
      tick();
      if (!held) k++;
    end
    idle();
    checks++; if (o_sc[0] !== 16'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3 (model events %0d)", o_sc[0], m_scnt[0]); end
    checks++; if (o_sc[1] !== 16'(sat(m_scnt[1], 1))) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=%0d", o_sc[1], sat(m_scnt[1], 1)); end
    // Set up a pending stall on the writer that was just issued, then reset between edges.
    held = 0;
    for (int c = 0; c < 6 && !held; c++) begin
      drive(1, 9 + k, 1, 0, 0, 10 + k, 1, 0, 0);
      held = e_stall[0];
      if (!held) begin tick(); k++; end
    end
    checks++; if (o_stall[0] !== 1'b1) begin failures++; $display("FAIL ars_pre got=%0b exp=1", o_stall[0]); end
    reset = 1'b1;
    #1;
    checks++; if (o_stall[0] !== 1'b0 || o_fie[0] !== 1'b0) begin failures++; $display("FAIL ars_stall got=%0b%0b exp=00", o_stall[0], o_fie[0]); end
    checks++; if (o_sc[0] !== 16'd0 || o_fc[0] !== 16'd0) begin failures++; $display("FAIL ars_cnt got=%0d/%0d exp=0/0", o_sc[0], o_fc[0]); end
    @(posedge clk);
    #1;
    checks++; if (o_sc[0] !== 16'd0 || o_sc[1] !== 16'd0) begin failures++; $display("FAIL ars_edge got=%0d/%0d exp=0/0", o_sc[0], o_sc[1]); end
    reset = 1'b0;
    model_reset();
    idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(7) != 0), $urandom_range(3), $urandom_range(1), $urandom_range(3),
            $urandom_range(1), $urandom_range(3), $urandom_range(1), $urandom_range(1),
            ($urandom_range(7) == 0));
      for (int m = 0; m < 2; m++) begin
        checks++; if (o_stall[m] !== e_stall[m]) begin failures++; $display("FAIL rnd_stall dut%0d cyc%0d got=%0b exp=%0b", m, c, o_stall[m], e_stall[m]); end
        checks++; if (o_fif[m] !== e_fif[m] || o_fie[m] !== e_fie[m]) begin failures++; $display("FAIL rnd_flush dut%0d cyc%0d got=%0b%0b exp=%0b%0b", m, c, o_fif[m], o_fie[m], e_fif[m], e_fie[m]); end
        checks++; if (o_wba[m] !== e_wba[m] || o_wbb[m] !== e_wbb[m]) begin failures++; $display("FAIL rnd_wbfwd dut%0d cyc%0d got=%0b%0b exp=%0b%0b", m, c, o_wba[m], o_wbb[m], e_wba[m], e_wbb[m]); end
        checks++; if (o_sa[m] !== 2'(m_sa[m]) || o_sb[m] !== 2'(m_sb[m])) begin failures++; $display("FAIL rnd_sel dut%0d cyc%0d got=%0d/%0d exp=%0d/%0d", m, c, o_sa[m], o_sb[m], m_sa[m], m_sb[m]); end
        checks++; if (o_sc[m] !== 16'(sat(m_scnt[m], m)) || o_fc[m] !== 16'(sat(m_fcnt[m], m))) begin failures++; $display("FAIL rnd_cnt dut%0d cyc%0d got=%0d/%0d exp=%0d/%0d", m, c, o_sc[m], o_fc[m], sat(m_scnt[m], m), sat(m_fcnt[m], m)); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_x0();
    test_jump_vs_stall();
    test_nofwd();
    test_saturate_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Hazard and forwarding controller for the five-stage (IF, ID, EX, MEM, WB) pipelined CPU. It is instantiated once in the CPU top next to the pipeline registers. It tracks in-flight destination registers in an internal EX/MEM/WB shadow pipeline and generates stall, flush and operand-forwarding selects. Compared with the single-cycle datapath it adds load-use interlocks, jump squashing, a no-forwarding mode and saturating stall/flush counters.

## Interface
- REG_ADDR_W, 5: register address width; address 0 is hardwired zero and never hazards.
- FWD_EN, 1: 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling.
- CNT_W, 16: width of the performance counters.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  ID source registers.
- id_rs1_used, id_rs2_used  in  1  the source is actually read.
- id_rd_addr  in  REG_ADDR_W  ID destination.
- id_rf_wen  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction's WB value comes from DATA_MEM.
- ex_jump_flag  in  1  the EX instruction redirects the PC (jump or taken branch).
- stall  out  1  hold PC and the IF/ID register.
- flush_if_id  out  1  turn IF/ID into a bubble.
- flush_id_ex  out  1  load a bubble into ID/EX.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 0 = ID/EX value, 1 = EX/MEM ALU result, 2 = MEM/WB write value; 3 is unused.
- id_wb_fwd_a, id_wb_fwd_b  out  1  ID must take the source from the WB write value, because REG_FILE has no write-through.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Shadow entries EX, MEM and WB each hold {valid, rd, rf_wen, is_load}.
- A producer "matches" a source when: the entry is valid, rf_wen = 1, rd != 0, rd equals the source address, and the corresponding *_used bit is 1.
- Jump: a jump is `ex_jump_flag` qualified by EX.valid. An unqualified `ex_jump_flag` is ignored.
- Hazard stall with FWD_EN=1: stall is raised when id_valid is set and either source matches the EX entry and EX.is_load = 1.
- Hazard stall with FWD_EN=0: stall is raised when id_valid is set and either source matches the EX or MEM entry.
- Jump priority: a jump forces stall = 0, flush_if_id = 1 and flush_id_ex = 1. Jump beats hazard stall.
- Stall without a jump: flush_id_ex = 1 and flush_if_id = 0.
- id_wb_fwd_a/b: asserted when the ID source matches the WB entry. This applies in both modes.
- Shadow pipeline advance, every edge:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID info when id_valid=1 and flush_id_ex=0; otherwise EX <= invalid.
- Forwarding selects:
  - With FWD_EN=1, fwd_x_sel is registered at the same edge from the pre-edge state.
  - Select 1 if the source matches the pre-edge EX entry (which becomes MEM) and that entry is not a load.
  - Otherwise select 2 if the source matches the pre-edge MEM entry (which becomes WB).
  - Otherwise select 0. The youngest producer wins.
  - Load-use hazards are guaranteed to resolve to select 2 after the one bubble.
- When a bubble is loaded into EX, fwd_x_sel <= 0.
- With FWD_EN=0, fwd_*_sel is constantly 0.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments on each cycle with flush_if_id = 1.
  - Both saturate at 2^CNT_W − 1.

## Timing
- stall, flush_if_id, flush_id_ex and id_wb_fwd_* are combinational from the shadow state and the current inputs. They are valid in the same cycle.
- fwd_*_sel is registered and is valid during the cycle the instruction occupies EX.
- Load-use costs exactly 1 stall cycle with FWD_EN=1.
- With FWD_EN=0, a back-to-back dependency costs 2 stall cycles; the third cycle uses id_wb_fwd.
- A jump costs 2 squashed instructions.
- Reset (asynchronous):
  - All shadow entries become invalid.
  - fwd_*_sel = 0 and the counters = 0.
  - Consequently stall = 0, flush_* = 0 and id_wb_fwd_* = 0 until instructions enter.
- Reset asserted mid-stall: the stall drops immediately, and nothing is counted on that edge.
- A simultaneous stall condition and jump is counted as a flush only.

## Test plan
- add x1; add x2 = x1 + x1 (FWD_EN=1) -> no stall; fwd_a_sel = fwd_b_sel = 1 in the consumer's EX cycle.
- lw x5; add x6 = x5 + x0 -> stall = flush_id_ex = 1 for 1 cycle; then fwd_a_sel = 2, fwd_b_sel = 0; stall_cnt = 1.
- Producer to x0, consumer reads x0 -> never a stall or forward; all selects 0.
- Jump in EX while a load-use stall is pending in ID -> stall = 0, flush_if_id = flush_id_ex = 1 for one cycle; flush_cnt = 1; the squashed ID instruction never appears in MEM.
- FWD_EN=0, add x3; add x4 = x3 -> stall for 2 cycles, then id_wb_fwd_a = 1; fwd_a_sel stays 0.
- CNT_W=2 with 5 consecutive stalls -> stall_cnt = 3 (saturated). Asynchronous reset mid-stall -> stall and counters 0 with no clock edge.
